cmp_unit_pipe: RTL and testbench
================================

# cmp_unit_pipe

Parametrised, pipelined signed/unsigned comparator and min/max tracker for the ALU compare slice. Accepts operand pairs on a valid/ready handshake, evaluates relational, min/max or running-extreme operations, and returns an encoded result plus relation flags two cycles later with full throughput and backpressure. It is the next generation of the ALU compare unit, adding signedness control, 3-bit mode select, a running accumulator and flow control.

## Interface
- DATA_WIDTH, 16, operand width (≥2)
- OUT_WIDTH, 16, result width (≥ DATA_WIDTH)
- CLK  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair valid
- in_ready  out  1  block accepts pair this cycle
- A, B  in  DATA_WIDTH each  operands
- ALU_FUN  in  3  operation select, sampled with operands
- SIGNED  in  1  1 = two's-complement compare, 0 = unsigned; sampled with operands
- acc_clr  in  1  clear running accumulator (level, any cycle)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- CMP_OUT  out  OUT_WIDTH  result
- CMP_Flags  out  3  {LT, GT, EQ} of the compared pair

## Operation
- Transfer in on in_valid & in_ready; out on out_valid & out_ready.
- ALU_FUN: 000 NOP → 0; 001 EQ → 1 if A==B else 0; 010 GT → 2 if A>B else 0; 011 LT → 3 if A<B else 0; 100 MIN → min(A,B); 101 MAX → max(A,B); 110 RMIN → acc = min(acc,A), out = new acc; 111 RMAX → acc = max(acc,A), out = new acc.
- Relational codes zero-extended to OUT_WIDTH; MIN/MAX/RMIN/RMAX values sign-extended when SIGNED=1, zero-extended otherwise.
- CMP_Flags: A vs B for modes 000–101 (NOP still reports flags); A vs acc for 110/111; exactly one bit set. For RMIN/RMAX on empty acc: flags = 001.
- Accumulator: DATA_WIDTH value plus acc_empty bit. On empty, RMIN/RMAX loads A. Signedness per transaction; mixing signedness across transactions is legal, compare uses current SIGNED.
- acc_clr: sets acc_empty=1 at next edge. If a RMIN/RMAX commits in the same cycle, clear wins first: the committing op sees empty acc, loads A, acc_empty ends 0.
- Non-run modes never modify acc.

## Timing
- Reset (rst low, async): out_valid=0, CMP_OUT=0, CMP_Flags=0, stage-1 valid=0, acc=0, acc_empty=1; in_ready=1 from first cycle after release. Reset mid-operation discards all in-flight pairs.
- Stage 1 registers A, B, ALU_FUN, SIGNED. Stage 2 computes against current acc and registers CMP_OUT/CMP_Flags, updating acc in the same edge (commit = stage-1 → stage-2 transfer).
- Latency 2 cycles accept-to-out_valid; one pair/cycle when out_ready=1.
- Stall: stage 2 holds when out_valid & !out_ready; stage 1 holds when stage 2 holds and stage 1 full; in_ready = !s1_valid | s1_advance (combinational from out_ready, no loop to in_valid).
- Back-to-back RMIN/RMAX: each sees acc updated by predecessor (no hazard, compare in stage 2).
- Outputs stable while out_valid & !out_ready.

## Structure
- Package cmp_pkg: ALU_FUN encodings, flag bit indices (EQ=0, GT=1, LT=2), relational code constants.
- Sub-module cmp_core: combinational DATA_WIDTH compare (signed/unsigned) → eq/gt/lt; instantiated once in stage 2 with mux selecting B or acc.

## Test plan
- Reset: assert rst mid-stream with 2 pairs in flight → out_valid=0, CMP_OUT=0, flags=0 immediately; after release RMIN A=5 → out 5.
- Signedness: A=16'hFFFF, B=1, GT: SIGNED=1 → CMP_OUT=0, flags=100; SIGNED=0 → CMP_OUT=2, flags=010; EQ A=B=7 → 1, flags=001.
- MIN/MAX: A=-3, B=4 signed, MIN → 16'hFFFD; MAX → 4; LT → 3.
- Running: acc_clr, RMAX stream 3, -2, 9, 9 signed, back-to-back → outputs 3, 3, 9, 9; flags 001, 100, 010, 001.
- Clear collision: acc=9, RMIN A=20 commits with acc_clr=1 → out 20, next RMIN A=25 → 20.
- Backpressure: 8 pairs continuous, out_ready toggles 1,0,0,1 pattern → in_ready drops after 2 buffered, no loss/duplication, results in order, outputs stable during stall.

Source files
------------

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared encodings for the pipelined compare unit.
//   alu_fun_e   - 3-bit operation select carried with each operand pair
//   FLG_*       - bit positions inside the 3-bit {LT, GT, EQ} flag vector
//   REL_*       - relational result codes (zero-extended onto CMP_OUT)
package cmp_pkg;

    typedef enum logic [2:0] {
        FUN_NOP  = 3'b000,
        FUN_EQ   = 3'b001,
        FUN_GT   = 3'b010,
        FUN_LT   = 3'b011,
        FUN_MIN  = 3'b100,
        FUN_MAX  = 3'b101,
        FUN_RMIN = 3'b110,
        FUN_RMAX = 3'b111
    } alu_fun_e;

    localparam int FLG_EQ = 0;
    localparam int FLG_GT = 1;
    localparam int FLG_LT = 2;

    localparam logic [1:0] REL_EQ = 2'd1;
    localparam logic [1:0] REL_GT = 2'd2;
    localparam logic [1:0] REL_LT = 2'd3;

endpackage

// File: rtl/cmp_core.sv
// cmp_core: combinational signed/unsigned magnitude compare.
//   a_i, b_i  - DATA_WIDTH operands
//   sgn_i     - 1 = two's complement, 0 = unsigned
//   eq_o, gt_o, lt_o - exactly one is set (a relative to b)
module cmp_core #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  sgn_i,
    output logic                  eq_o,
    output logic                  gt_o,
    output logic                  lt_o
);

    logic [DATA_WIDTH-1:0] a_x;
    logic [DATA_WIDTH-1:0] b_x;

    // Flipping the sign bits maps two's complement order onto unsigned
    // order, so one unsigned comparator serves both modes.
    always_comb begin
        a_x = a_i;
        b_x = b_i;
        a_x[DATA_WIDTH-1] = a_i[DATA_WIDTH-1] ^ sgn_i;
        b_x[DATA_WIDTH-1] = b_i[DATA_WIDTH-1] ^ sgn_i;
    end

    assign eq_o = (a_x == b_x);
    assign gt_o = (a_x >  b_x);
    assign lt_o = (a_x <  b_x);

endmodule

// File: rtl/cmp_unit_pipe.sv
// cmp_unit_pipe: two-stage compare / min-max / running-extreme unit.
//   CLK, rst            - rising-edge clock, async active-low reset
//   in_valid/in_ready   - operand handshake (A, B, ALU_FUN, SIGNED)
//   acc_clr             - empties the running accumulator at the next edge
//   out_valid/out_ready - result handshake
//   CMP_OUT             - relational code or (sign/zero-extended) value
//   CMP_Flags           - {LT, GT, EQ} of A vs B, or A vs acc for run modes
// Stage 1 registers the request; stage 2 evaluates against the live
// accumulator and updates it on the same edge, so back-to-back running
// ops see their predecessor's result without forwarding.
module cmp_unit_pipe
    import cmp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OUT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    input  logic [2:0]            ALU_FUN,
    input  logic                  SIGNED,
    input  logic                  acc_clr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  CMP_OUT,
    output logic [2:0]            CMP_Flags
);

    // stage 1
    logic                  s1_valid_q;
    logic [DATA_WIDTH-1:0] a_q, b_q;
    alu_fun_e              fun_q;
    logic                  sgn_q;

    // stage 2 / accumulator
    logic                  out_valid_q;
    logic [OUT_WIDTH-1:0]  cmp_out_q, cmp_out_d;
    logic [2:0]            flags_q, flags_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  acc_empty_q, acc_empty_d;

    logic s2_hold, commit;
    logic run_op, eff_empty;
    logic [DATA_WIDTH-1:0] cmp_b;
    logic eq, gt, lt;
    logic [DATA_WIDTH-1:0] res_val;
    logic [1:0]            rel;
    logic                  use_val;
    logic [OUT_WIDTH-1:0]  ext_s, ext_u;

    assign s2_hold  = out_valid_q & ~out_ready;
    assign commit   = s1_valid_q & ~s2_hold;
    assign in_ready = ~s1_valid_q | ~s2_hold;

    assign run_op    = (fun_q == FUN_RMIN) || (fun_q == FUN_RMAX);
    // A clear in the commit cycle takes effect first: the op sees empty.
    assign eff_empty = acc_empty_q | acc_clr;
    assign cmp_b     = run_op ? acc_q : b_q;

    cmp_core #(.DATA_WIDTH(DATA_WIDTH)) u_core (
        .a_i   (a_q),
        .b_i   (cmp_b),
        .sgn_i (sgn_q),
        .eq_o  (eq),
        .gt_o  (gt),
        .lt_o  (lt)
    );

    always_comb begin
        res_val          = '0;
        rel              = '0;
        use_val          = 1'b0;
        flags_d          = '0;
        flags_d[FLG_EQ]  = eq;
        flags_d[FLG_GT]  = gt;
        flags_d[FLG_LT]  = lt;
        acc_d            = acc_q;
        acc_empty_d      = acc_clr ? 1'b1 : acc_empty_q;
        if (commit) begin
            case (fun_q)
                FUN_NOP: rel = '0;
                FUN_EQ:  rel = eq ? REL_EQ : 2'd0;
                FUN_GT:  rel = gt ? REL_GT : 2'd0;
                FUN_LT:  rel = lt ? REL_LT : 2'd0;
                FUN_MIN: begin use_val = 1'b1; res_val = lt ? a_q : b_q; end
                FUN_MAX: begin use_val = 1'b1; res_val = gt ? a_q : b_q; end
                FUN_RMIN, FUN_RMAX: begin
                    use_val = 1'b1;
                    if (eff_empty) begin
                        res_val = a_q;
                        flags_d = '0;
                        flags_d[FLG_EQ] = 1'b1;
                    end else if (fun_q == FUN_RMIN) begin
                        res_val = lt ? a_q : acc_q;
                    end else begin
                        res_val = gt ? a_q : acc_q;
                    end
                    acc_d       = res_val;
                    acc_empty_d = 1'b0;
                end
                default: rel = '0;
            endcase
        end
    end

    assign ext_s     = OUT_WIDTH'($signed(res_val));
    assign ext_u     = OUT_WIDTH'(res_val);
    assign cmp_out_d = use_val ? (sgn_q ? ext_s : ext_u) : OUT_WIDTH'(rel);

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            fun_q       <= FUN_NOP;
            sgn_q       <= 1'b0;
            out_valid_q <= 1'b0;
            cmp_out_q   <= '0;
            flags_q     <= '0;
            acc_q       <= '0;
            acc_empty_q <= 1'b1;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    a_q   <= A;
                    b_q   <= B;
                    fun_q <= alu_fun_e'(ALU_FUN);
                    sgn_q <= SIGNED;
                end
            end
            if (!s2_hold) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    cmp_out_q <= cmp_out_d;
                    flags_q   <= flags_d;
                end
            end
            acc_q       <= acc_d;
            acc_empty_q <= acc_empty_d;
        end
    end

    assign out_valid = out_valid_q;
    assign CMP_OUT   = cmp_out_q;
    assign CMP_Flags = flags_q;

endmodule

// File: tb/tb_cmp_unit_pipe.sv
module tb_cmp_unit_pipe;

    localparam int DW = 16;
    localparam int OW = 16;

    logic          CLK = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] A = '0, B = '0;
    logic [2:0]    ALU_FUN = '0;
    logic          SIGNED = 1'b0;
    logic          acc_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [OW-1:0] CMP_OUT;
    logic [2:0]    CMP_Flags;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    cmp_unit_pipe #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) dut (
        .CLK(CLK), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALU_FUN(ALU_FUN), .SIGNED(SIGNED),
        .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .CMP_OUT(CMP_OUT), .CMP_Flags(CMP_Flags)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // vector table: a, b, fun, sgn, clr-at-commit, expected out, expected flags
    typedef struct {
        logic [15:0] a, b;
        logic [2:0]  fun;
        logic        sgn, clr;
        logic [15:0] eo;
        logic [2:0]  ef;
    } vec_t;

    vec_t vq[$];
    int   stall_seen;

    task automatic push(input logic [15:0] a, b, input logic [2:0] fun,
                        input logic sgn, clr, input logic [15:0] eo, input logic [2:0] ef);
        vec_t v;
        v.a = a; v.b = b; v.fun = fun; v.sgn = sgn; v.clr = clr; v.eo = eo; v.ef = ef;
        vq.push_back(v);
    endtask

    // Drive vq through the DUT; bp=1 applies out_ready pattern 1,0,0,1.
    task automatic run(input bit bp, input string name);
        int idx = 0, ochk = 0, cyc = 0;
        bit clr_pend = 0, stall_prev = 0;
        logic [15:0] held_o;
        logic [2:0]  held_f;
        while ((idx < vq.size() || ochk < vq.size()) && cyc < 200) begin
            @(negedge CLK);
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            acc_clr   = clr_pend;
            clr_pend  = 0;
            if (idx < vq.size()) begin
                in_valid = 1'b1;
                A = vq[idx].a; B = vq[idx].b; ALU_FUN = vq[idx].fun; SIGNED = vq[idx].sgn;
            end else in_valid = 1'b0;
            #1;
            if (stall_prev) begin
                chk({name, "_stall_out"}, 32'(CMP_OUT), 32'(held_o));
                chk({name, "_stall_flg"}, 32'(CMP_Flags), 32'(held_f));
            end
            if (out_valid && out_ready) begin
                if (ochk < vq.size()) begin
                    chk($sformatf("%s_out%0d", name, ochk), 32'(CMP_OUT), 32'(vq[ochk].eo));
                    chk($sformatf("%s_flg%0d", name, ochk), 32'(CMP_Flags), 32'(vq[ochk].ef));
                end else chk({name, "_extra_out"}, 32'(ochk), 32'(vq.size()));
                ochk++;
            end
            stall_prev = out_valid && !out_ready;
            held_o = CMP_OUT; held_f = CMP_Flags;
            if (!in_ready) stall_seen = 1;
            if (in_valid && in_ready) begin
                clr_pend = vq[idx].clr;
                idx++;
            end
            cyc++;
        end
        chk({name, "_count"}, 32'(ochk), 32'(vq.size()));
        @(negedge CLK);
        in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        vq.delete();
    endtask

    initial begin
        // reset state
        #12;
        chk("rst_ovalid", 32'(out_valid), 0);
        chk("rst_out", 32'(CMP_OUT), 0);
        chk("rst_flg", 32'(CMP_Flags), 0);
        @(negedge CLK); rst = 1'b1;
        @(negedge CLK);
        chk("rst_inready", 32'(in_ready), 1);

        // directed functions; fun: 0 NOP 1 EQ 2 GT 3 LT 4 MIN 5 MAX 6 RMIN 7 RMAX
        push(16'hFFFF, 16'd1, 3'd2, 1, 0, 16'd0,    3'b100);
        push(16'hFFFF, 16'd1, 3'd2, 0, 0, 16'd2,    3'b010);
        push(16'd7,    16'd7, 3'd1, 1, 0, 16'd1,    3'b001);
        push(16'hFFFD, 16'd4, 3'd4, 1, 0, 16'hFFFD, 3'b100);
        push(16'hFFFD, 16'd4, 3'd5, 1, 0, 16'd4,    3'b100);
        push(16'hFFFD, 16'd4, 3'd3, 1, 0, 16'd3,    3'b100);
        push(16'd5,    16'd5, 3'd0, 1, 0, 16'd0,    3'b001);
        push(16'hFFFD, 16'd4, 3'd4, 0, 0, 16'd4,    3'b010);
        // running max: clear then 3, -2, 9, 9
        push(16'd3,    16'd0, 3'd7, 1, 1, 16'd3,    3'b001);
        push(16'hFFFE, 16'd0, 3'd7, 1, 0, 16'd3,    3'b100);
        push(16'd9,    16'd0, 3'd7, 1, 0, 16'd9,    3'b010);
        push(16'd9,    16'd0, 3'd7, 1, 0, 16'd9,    3'b001);
        // clear collides with RMIN commit: op sees empty acc
        push(16'd20,   16'd0, 3'd6, 1, 1, 16'd20,   3'b001);
        push(16'd25,   16'd0, 3'd6, 1, 0, 16'd20,   3'b010);
        // non-run op leaves acc alone; mixed signedness on acc
        push(16'd100,  16'd200, 3'd5, 0, 0, 16'd200, 3'b100);
        push(16'hFFFF, 16'd0, 3'd6, 0, 0, 16'd20,   3'b010);
        push(16'hFFFF, 16'd0, 3'd6, 1, 0, 16'hFFFF, 3'b100);
        run(0, "func");

        // backpressure: MAX unsigned of 3*i vs 10
        stall_seen = 0;
        for (int i = 0; i < 8; i++) begin
            logic [15:0] av;
            av = 16'(3 * i);
            if (av > 16'd10) push(av, 16'd10, 3'd5, 0, 0, av, 3'b010);
            else             push(av, 16'd10, 3'd5, 0, 0, 16'd10, 3'b100);
        end
        run(1, "bp");
        chk("bp_inready_drop", 32'(stall_seen), 1);

        // reset with two pairs in flight
        @(negedge CLK);
        out_ready = 1'b0; in_valid = 1'b1; A = 16'd1; B = 16'd1; ALU_FUN = 3'd1; SIGNED = 0;
        @(negedge CLK);
        A = 16'd2; B = 16'd2;
        @(negedge CLK);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_ovalid", 32'(out_valid), 1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_ovalid", 32'(out_valid), 0);
        chk("mid_rst_out", 32'(CMP_OUT), 0);
        chk("mid_rst_flg", 32'(CMP_Flags), 0);
        @(negedge CLK); rst = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        #1;
        chk("post_rst_inready", 32'(in_ready), 1);
        chk("post_rst_ovalid", 32'(out_valid), 0);
        push(16'd5, 16'd0, 3'd6, 1, 0, 16'd5, 3'b001);
        run(0, "rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
